// File: rtl/decode_wb.sv
// decode_wb: Y86 decode/writeback stage.
// Owns the register file, selects and reads the source operands, and holds the
// D->E pipeline register behind a valid/ready handshake. Writeback from the
// tail of the pipe updates the register file every cycle, whether or not the
// stage is stalled.
// Optional build macro: WB_BYPASS_EN. When it is defined, a same-cycle
// writeback is forwarded into the operand read (write-before-read).
module decode_wb #(
  parameter int unsigned NREGS    = 8,
  parameter logic [31:0] RESET_SP = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  icode_i,
  input  logic [7:0]  ifun_i,
  input  logic [3:0]  rA_i,
  input  logic [3:0]  rB_i,
  input  logic [31:0] valC_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  icode_o,
  output logic [7:0]  ifun_o,
  output logic [31:0] valA_o,
  output logic [31:0] valB_o,
  output logic [31:0] valC_o,
  output logic [3:0]  dstE_o,
  output logic [3:0]  dstM_o,
  input  logic        wb_valid,
  input  logic [3:0]  wb_dstE,
  input  logic [31:0] wb_valE,
  input  logic [3:0]  wb_dstM,
  input  logic [31:0] wb_valM
);

  localparam int unsigned AW     = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [3:0]  NREGS4 = 4'(NREGS);
  localparam logic [3:0]  RNONE  = 4'hF;
  localparam logic [3:0]  RESP   = 4'h4;

  typedef enum logic [7:0] {
    I_HALT   = 8'h00,
    I_NOP    = 8'h01,
    I_CMOVXX = 8'h02,
    I_IRMOVL = 8'h03,
    I_RMMOVL = 8'h04,
    I_MRMOVL = 8'h05,
    I_OPL    = 8'h06,
    I_JXX    = 8'h07,
    I_CALL   = 8'h08,
    I_RET    = 8'h09,
    I_PUSHL  = 8'h0A,
    I_POPL   = 8'h0B
  } icode_t;

  logic [31:0] rf [NREGS];

  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [31:0] rdA, rdB;
  logic        load;
  logic        wbE_ok, wbM_ok;

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;
  assign wbE_ok   = wb_valid && (wb_dstE < NREGS4);
  assign wbM_ok   = wb_valid && (wb_dstM < NREGS4);

  // Register read: out-of-range or RNONE specifiers read as zero.
  function automatic logic [31:0] rd(input logic [3:0] src);
    logic [31:0] v;
    v = '0;
    if (src < NREGS4) begin
      v = rf[src[AW-1:0]];
`ifdef WB_BYPASS_EN
      if (wbE_ok && (wb_dstE == src)) v = wb_valE;
      if (wbM_ok && (wb_dstM == src)) v = wb_valM;
`endif
    end
    return v;
  endfunction

  // Source and destination selection from the instruction code.
  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (icode_i)
      I_CMOVXX: begin srcA = rA_i;                 dstE = rB_i; end
      I_IRMOVL: begin                                dstE = rB_i; end
      I_RMMOVL: begin srcA = rA_i; srcB = rB_i;                  end
      I_MRMOVL: begin              srcB = rB_i;    dstM = rA_i; end
      I_OPL:    begin srcA = rA_i; srcB = rB_i;    dstE = rB_i; end
      I_CALL:   begin              srcB = RESP;    dstE = RESP; end
      I_RET:    begin srcA = RESP; srcB = RESP;    dstE = RESP; end
      I_PUSHL:  begin srcA = rA_i; srcB = RESP;    dstE = RESP; end
      I_POPL:   begin srcA = RESP; srcB = RESP;    dstE = RESP; dstM = rA_i; end
      default:  begin end
    endcase
  end

  // Operand read for the instruction being accepted this cycle.
  always_comb begin
    rdA = rd(srcA);
    rdB = rd(srcB);
  end

  // Register file: reset image, then writeback with valM taking priority
  // when both ports target the same register (later assignment wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++)
        rf[AW'(i)] <= (i == 4) ? RESET_SP : '0;
    end else begin
      if (wbE_ok) rf[wb_dstE[AW-1:0]] <= wb_valE;
      if (wbM_ok) rf[wb_dstM[AW-1:0]] <= wb_valM;
    end
  end

  // D->E pipeline register; a stalled instruction keeps its captured operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      icode_o   <= '0;
      ifun_o    <= '0;
      valA_o    <= '0;
      valB_o    <= '0;
      valC_o    <= '0;
      dstE_o    <= RNONE;
      dstM_o    <= RNONE;
    end else if (load) begin
      out_valid <= 1'b1;
      icode_o   <= icode_i;
      ifun_o    <= ifun_i;
      valA_o    <= rdA;
      valB_o    <= rdB;
      valC_o    <= valC_i;
      dstE_o    <= dstE;
      dstM_o    <= dstM;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_wb.sv
// Directed bench for decode_wb: register reads/writes, handshake stall and
// drain, writeback port priority, bypass behaviour and reset priority.
module tb_decode_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [7:0]  icode_i, ifun_i;
  logic [3:0]  rA_i, rB_i;
  logic [31:0] valC_i;
  logic        out_valid, out_ready;
  logic [7:0]  icode_o, ifun_o;
  logic [31:0] valA_o, valB_o, valC_o;
  logic [3:0]  dstE_o, dstM_o;
  logic        wb_valid;
  logic [3:0]  wb_dstE, wb_dstM;
  logic [31:0] wb_valE, wb_valM;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  decode_wb #(.NREGS(8), .RESET_SP(32'h0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .icode_i(icode_i), .ifun_i(ifun_i), .rA_i(rA_i), .rB_i(rB_i), .valC_i(valC_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .icode_o(icode_o), .ifun_o(ifun_o), .valA_o(valA_o), .valB_o(valB_o),
    .valC_o(valC_o), .dstE_o(dstE_o), .dstM_o(dstM_o),
    .wb_valid(wb_valid), .wb_dstE(wb_dstE), .wb_valE(wb_valE),
    .wb_dstM(wb_dstM), .wb_valM(wb_valM)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [3:0] de, input logic [31:0] ve,
                    input logic [3:0] dm, input logic [31:0] vm);
    wb_valid = 1'b1; wb_dstE = de; wb_valE = ve; wb_dstM = dm; wb_valM = vm;
    tick();
    wb_valid = 1'b0; wb_dstE = 4'hF; wb_dstM = 4'hF;
  endtask

  task automatic issue(input logic [7:0] ic, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [31:0] vc);
    in_valid = 1'b1; icode_i = ic; ifun_i = 8'h0; rA_i = ra; rB_i = rb; valC_i = vc;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    icode_i = '0; ifun_i = '0; rA_i = 4'hF; rB_i = 4'hF; valC_i = '0;
    wb_valid = 1'b0; wb_dstE = 4'hF; wb_valE = '0; wb_dstM = 4'hF; wb_valM = '0;
    #2;
    tick();
    rst = 1'b0;

    // 1: reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dstE", 32'(dstE_o), 32'hF);
    check("rst_dstM", 32'(dstM_o), 32'hF);
    check("rst_valA", valA_o, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    issue(8'h02, 4'h0, 4'h1, 32'h0);           // RRMOVL eax -> ecx
    check("rst_eax_read", valA_o, 32'h0);
    check("rrmovl_dstE", 32'(dstE_o), 32'h1);
    tick();
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // 2: writeback then OPL ADDL eax, ebx
    wb(4'h0, 32'h11, 4'h3, 32'h22);
    in_valid = 1'b1; icode_i = 8'h06; ifun_i = 8'h0; rA_i = 4'h0; rB_i = 4'h3; valC_i = 32'h5;
    tick();
    in_valid = 1'b0;
    check("opl_valA", valA_o, 32'h11);
    check("opl_valB", valB_o, 32'h22);
    check("opl_dstE", 32'(dstE_o), 32'h3);
    check("opl_dstM", 32'(dstM_o), 32'hF);
    check("opl_out_valid", 32'(out_valid), 32'd1);
    check("opl_icode", 32'(icode_o), 32'h06);

    // 3: stall three cycles while writing eax; a new instruction is offered
    out_ready = 1'b0;
    in_valid = 1'b1; icode_i = 8'h03; rA_i = 4'hF; rB_i = 4'h7; valC_i = 32'h1234;
    wb_valid = 1'b1; wb_dstE = 4'h0; wb_valE = 32'h99; wb_dstM = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valA", valA_o, 32'h11);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_icode", 32'(icode_o), 32'h06);
    end
    wb_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("unstall_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("unstall_out_valid", 32'(out_valid), 32'd0);
    issue(8'h02, 4'h0, 4'h1, 32'h0);
    check("stalled_wb_landed", valA_o, 32'h99);

    // 4: both ports to edx, valM wins
    wb(4'h2, 32'h5, 4'h2, 32'h7);
    issue(8'h02, 4'h2, 4'h1, 32'h0);
    check("wb_prio_edx", valA_o, 32'h7);

    // 5: same-cycle write and read of eax
    wb_valid = 1'b1; wb_dstE = 4'h0; wb_valE = 32'hAB; wb_dstM = 4'hF;
    issue(8'h02, 4'h0, 4'h5, 32'h0);
    wb_valid = 1'b0; wb_dstE = 4'hF;
`ifdef WB_BYPASS_EN
    check("same_cycle_read", valA_o, 32'hAB);
`else
    check("same_cycle_read", valA_o, 32'h99);
`endif
    issue(8'h02, 4'h0, 4'h5, 32'h0);
    check("eax_after_write", valA_o, 32'hAB);

    // out-of-range destination ID 8 must not alias onto eax
    wb(4'h8, 32'hDEAD, 4'hF, 32'hBEEF);
    issue(8'h02, 4'h0, 4'h5, 32'h0);
    check("id8_ignored", valA_o, 32'hAB);

    // 6: POPL esi with esp = 0x100
    wb(4'h4, 32'h100, 4'hF, 32'h0);
    issue(8'h0B, 4'h6, 4'hF, 32'h0);
    check("popl_valA", valA_o, 32'h100);
    check("popl_valB", valB_o, 32'h100);
    check("popl_dstE", 32'(dstE_o), 32'h4);
    check("popl_dstM", 32'(dstM_o), 32'h6);

    // PUSHL edx: srcA=rA, srcB=esp
    issue(8'h0A, 4'h2, 4'hF, 32'h0);
    check("pushl_valA", valA_o, 32'h7);
    check("pushl_valB", valB_o, 32'h100);
    check("pushl_dstM", 32'(dstM_o), 32'hF);

    // MRMOVL: srcB=rB, dstM=rA, no dstE
    issue(8'h05, 4'h1, 4'h0, 32'h40);
    check("mrmovl_valB", valB_o, 32'hAB);
    check("mrmovl_dstE", 32'(dstE_o), 32'hF);
    check("mrmovl_dstM", 32'(dstM_o), 32'h1);
    check("mrmovl_valC", valC_o, 32'h40);

    // unknown icode: no sources, no destinations
    issue(8'h0C, 4'h0, 4'h2, 32'hCAFE);
    check("unk_valA", valA_o, 32'h0);
    check("unk_valB", valB_o, 32'h0);
    check("unk_dstE", 32'(dstE_o), 32'hF);
    check("unk_valC", valC_o, 32'hCAFE);

    // reset wins over a concurrent writeback
    rst = 1'b1;
    wb(4'h0, 32'h55, 4'h4, 32'h66);
    rst = 1'b0;
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    issue(8'h09, 4'hF, 4'hF, 32'h0);            // RET reads esp twice
    check("rst2_esp", valA_o, 32'h0);
    issue(8'h02, 4'h0, 4'h1, 32'h0);
    check("rst2_eax", valA_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
